// File: rtl/yout_buffer.sv
// Y-bus output FIFO: captures yalu or zero-extended yss (optional 32-bit mask) into DEPTH 64-bit entries; optional per-entry parity when YOUT_PARITY_EN is defined.
// Latency 1: a word loaded into an empty buffer is visible on out_data/out_valid the next cycle; there is no same-cycle bypass.
// Backpressure: the head holds while out_ready=0; a load into a full buffer with no pop is dropped and latches sticky ovf.
module yout_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] yalu,
  input  logic [3:0]  yss,
  input  logic        ysel,
  input  logic        mode32,
  input  logic        load,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
`ifdef YOUT_PARITY_EN
  output logic [7:0]  out_par,
`endif
  output logic        full,
  output logic [2:0]  count,
  output logic        ovf
);

  localparam int AW = (DEPTH > 2) ? 2 : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    count_q;
  logic          ovf_q;
  logic [63:0]   cap_word;
  logic          pop;
  logic          push;
  logic          drop;

`ifdef YOUT_PARITY_EN
  logic [7:0] par_mem [DEPTH];
  logic [7:0] cap_par;

  // Odd parity per byte of the captured word: bit set when the byte has an even number of ones.
  always_comb begin
    cap_par = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cap_par[i] = ~(^cap_word[8*i +: 8]);
    end
  end

  // Parity travels with its entry so it needs no recomputation on the read side.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      par_mem[wr_ptr] <= cap_par;
    end
  end

  // Empty buffer presents all-zero data, whose odd parity is 1 in every byte.
  always_comb begin
    out_par = (count_q == 3'd0) ? 8'hFF : par_mem[rd_ptr];
  end
`endif

  // Select the source and apply the 32-bit mode mask to the upper half.
  always_comb begin
    cap_word = ysel ? {60'b0, yss} : yalu;
    if (mode32) begin
      cap_word[63:32] = 32'b0;
    end
  end

  // Handshake: a pop frees a slot in the same cycle, so a full buffer can still accept a load.
  always_comb begin
    pop  = (count_q != 3'd0) && out_ready;
    push = load && ((count_q != 3'(DEPTH)) || pop);
    drop = load && !push;
  end

  // Entry storage; contents need no reset because empty reads are forced to zero.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= cap_word;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      count_q <= count_q + {2'b0, push} - {2'b0, pop};
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Outputs depend only on registered state, never on load or the Y inputs.
  always_comb begin
    count     = count_q;
    out_valid = (count_q != 3'd0);
    full      = (count_q == 3'(DEPTH));
    ovf       = ovf_q;
    out_data  = (count_q == 3'd0) ? 64'd0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_yout_buffer.sv
// Bench for yout_buffer: directed scenarios plus randomized traffic against a queue model.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
// Expected values come from the constants of each scenario or from the queue model.
module tb_yout_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] yalu;
  logic [3:0]  yss;
  logic        ysel;
  logic        mode32;
  logic        load;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        full;
  logic [2:0]  count;
  logic        ovf;
`ifdef YOUT_PARITY_EN
  logic [7:0]  out_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  logic        m_ovf;

  always #5 clk = ~clk;

  yout_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .yalu      (yalu),
    .yss       (yss),
    .ysel      (ysel),
    .mode32    (mode32),
    .load      (load),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef YOUT_PARITY_EN
    .out_par   (out_par),
`endif
    .full      (full),
    .count     (count),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and advance the reference model by the same cycle.
  task automatic step(input logic ld, input logic [63:0] ya, input logic [3:0] ys,
                      input logic sel, input logic m32, input logic rdy);
    logic [63:0] w;
    logic        do_pop;
    logic        do_push;
    load = ld; yalu = ya; yss = ys; ysel = sel; mode32 = m32; out_ready = rdy;
    w = sel ? 64'(yss) : ya;
    if (m32) w = w & 64'h0000_0000_FFFF_FFFF;
    do_pop  = (mq.size() > 0) && rdy;
    do_push = ld && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(w);
    if (ld && !do_push) m_ovf = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0; load = 1'b0; out_ready = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    yalu = 64'hDEAD_BEEF_0000_1111; yss = 4'h0; ysel = 1'b0; mode32 = 1'b0;
    do_reset();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_basic_load();
    step(1'b1, 64'h0123_4567_89AB_CDEF, 4'h0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL basic_data got %h want 0123456789abcdef", out_data); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL basic_count got %0d want 1", count); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin n_err++; $display("FAIL basic_drain got valid=%b data=%h want 0/0", out_valid, out_data); end
  endtask

  task automatic test_mode32_ysel();
    step(1'b1, 64'h0123_4567_89AB_CDEF, 4'h0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_data !== 64'h0000_0000_89AB_CDEF) begin n_err++; $display("FAIL mode32_data got %h want 0000000089abcdef", out_data); end
    // Pop the masked word while loading the yss word in the same cycle.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (out_data !== 64'hA || count !== 3'd1) begin n_err++; $display("FAIL ysel_data got %h count %0d want a count 1", out_data, count); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    step(1'b1, 64'd1, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", ovf); end
    step(1'b1, 64'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (full !== 1'b1 || count !== 3'd2 || ovf !== 1'b1) begin n_err++; $display("FAIL ovf_state got full=%b count=%0d ovf=%b want 1/2/1", full, count, ovf); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 64'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_hold got %h want 1", out_data); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_data !== 64'd2) begin n_err++; $display("FAIL ovf_pop2 got %h want 2", out_data); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin n_err++; $display("FAIL ovf_no3 got valid=%b data=%h want 0/0", out_valid, out_data); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    do_reset();
  endtask

  task automatic test_full_push_pop();
    step(1'b1, 64'h10, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h11, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h12, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (count !== 3'd2 || ovf !== 1'b0) begin n_err++; $display("FAIL fullpp_state got count=%0d ovf=%b want 2/0", count, ovf); end
    n_cmp++; if (out_data !== 64'h11) begin n_err++; $display("FAIL fullpp_head got %h want 11", out_data); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_data !== 64'h12) begin n_err++; $display("FAIL fullpp_order got %h want 12", out_data); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 64'h21, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h22, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h23, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; load = 1'b1; out_ready = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 64'd0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL midreset got count=%0d valid=%b data=%h ovf=%b want 0/0/0/0", count, out_valid, out_data, ovf);
    end
    reset = 1'b0; mq.delete(); m_ovf = 1'b0;
    step(1'b1, 64'h55, 4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h55) begin n_err++; $display("FAIL midreset_reload got valid=%b data=%h want 1/55", out_valid, out_data); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef YOUT_PARITY_EN
  task automatic test_parity();
    n_cmp++; if (out_par !== 8'hFF) begin n_err++; $display("FAIL par_empty got %h want ff", out_par); end
    step(1'b1, 64'h0000_0000_0000_0001, 4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_par !== 8'hFE) begin n_err++; $display("FAIL par_one got %h want fe", out_par); end
    step(1'b0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    logic [63:0] exp_data;
    logic [7:0]  exp_par;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), {$urandom, $urandom}, 4'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 5));
      exp_data = (mq.size() > 0) ? mq[0] : 64'd0;
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, mq.size() > 0); end
      n_cmp++; if (out_data !== exp_data) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", i, out_data, exp_data); end
      n_cmp++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, mq.size()); end
      n_cmp++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full cyc %0d got %b want %b", i, full, mq.size() == DEPTH); end
      n_cmp++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, ovf, m_ovf); end
      exp_par = 8'h00;
      for (int b = 0; b < 8; b++) exp_par[b] = ~(^exp_data[8*b +: 8]);
`ifdef YOUT_PARITY_EN
      n_cmp++; if (out_par !== exp_par) begin n_err++; $display("FAIL rnd_par cyc %0d got %h want %h", i, out_par, exp_par); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; out_ready = 1'b0;
    yalu = 64'd0; yss = 4'h0; ysel = 1'b0; mode32 = 1'b0;
    m_ovf = 1'b0;
    test_reset();
    test_basic_load();
    test_mode32_ysel();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
`ifdef YOUT_PARITY_EN
    test_parity();
`endif
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
